// File: rtl/sm_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between
// the instruction-fetch port (I) and the load/store port (D).
module sm_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  m_en,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy
);

    if ((MEM_LATENCY == 0) || (MEM_LATENCY > 7)) begin : g_bad_latency
        $fatal(1, "sm_mem_arbiter: MEM_LATENCY must be within 1..7");
    end

    localparam logic [2:0] LatCnt = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                r_state;
    logic [2:0]            r_cnt;
    logic                  r_last_grant_is_d;
    logic                  r_sel_is_d;
    logic                  r_m_en;
    logic                  r_m_we;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic                  r_i_ack;
    logic                  r_d_ack;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_busy;

    state_e                w_state_d;
    logic [2:0]            w_cnt_d;
    logic                  w_last_grant_is_d_d;
    logic                  w_sel_is_d_d;
    logic                  w_grant_is_d;
    logic                  w_m_en_d;
    logic                  w_m_we_d;
    logic [ADDR_WIDTH-1:0] w_m_addr_d;
    logic [DATA_WIDTH-1:0] w_m_wdata_d;
    logic                  w_i_ack_d;
    logic                  w_d_ack_d;
    logic [DATA_WIDTH-1:0] w_i_rdata_d;
    logic [DATA_WIDTH-1:0] w_d_rdata_d;
    logic                  w_busy_d;

    always_comb begin
        w_state_d           = r_state;
        w_cnt_d             = r_cnt;
        w_last_grant_is_d_d = r_last_grant_is_d;
        w_sel_is_d_d        = r_sel_is_d;
        w_grant_is_d        = 1'b0;
        w_m_en_d            = 1'b0;
        w_m_we_d            = r_m_we;
        w_m_addr_d          = r_m_addr;
        w_m_wdata_d         = r_m_wdata;
        w_i_ack_d           = 1'b0;
        w_d_ack_d           = 1'b0;
        w_i_rdata_d         = r_i_rdata;
        w_d_rdata_d         = r_d_rdata;

        unique case (r_state)
            StIdle: begin
                if (i_req || d_req) begin
                    // On contention the port that did not win last time goes first.
                    w_grant_is_d        = d_req && (!i_req || !r_last_grant_is_d);
                    w_sel_is_d_d        = w_grant_is_d;
                    w_last_grant_is_d_d = w_grant_is_d;
                    w_m_en_d            = 1'b1;
                    w_m_we_d            = w_grant_is_d && d_we;
                    w_m_addr_d          = w_grant_is_d ? d_addr : i_addr;
                    if (w_grant_is_d) begin
                        w_m_wdata_d = d_wdata;
                    end
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                w_cnt_d   = LatCnt;
                w_state_d = StWait;
            end
            StWait: begin
                w_cnt_d = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    if (!r_m_we) begin
                        if (r_sel_is_d) begin
                            w_d_rdata_d = m_rdata;
                        end else begin
                            w_i_rdata_d = m_rdata;
                        end
                    end
                    w_d_ack_d = r_sel_is_d;
                    w_i_ack_d = !r_sel_is_d;
                    w_state_d = StResp;
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= StIdle;
            r_cnt             <= 3'd0;
            r_last_grant_is_d <= 1'b1;
            r_sel_is_d        <= 1'b0;
            r_m_en            <= 1'b0;
            r_m_we            <= 1'b0;
            r_m_addr          <= '0;
            r_m_wdata         <= '0;
            r_i_ack           <= 1'b0;
            r_d_ack           <= 1'b0;
            r_i_rdata         <= '0;
            r_d_rdata         <= '0;
            r_busy            <= 1'b0;
        end else begin
            r_state           <= w_state_d;
            r_cnt             <= w_cnt_d;
            r_last_grant_is_d <= w_last_grant_is_d_d;
            r_sel_is_d        <= w_sel_is_d_d;
            r_m_en            <= w_m_en_d;
            r_m_we            <= w_m_we_d;
            r_m_addr          <= w_m_addr_d;
            r_m_wdata         <= w_m_wdata_d;
            r_i_ack           <= w_i_ack_d;
            r_d_ack           <= w_d_ack_d;
            r_i_rdata         <= w_i_rdata_d;
            r_d_rdata         <= w_d_rdata_d;
            r_busy            <= w_busy_d;
        end
    end

    assign i_rdata = r_i_rdata;
    assign i_ack   = r_i_ack;
    assign d_rdata = r_d_rdata;
    assign d_ack   = r_d_ack;
    assign m_en    = r_m_en;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Bench for sm_mem_arbiter: two instances (latency 1 and 3) share the stimulus; each has
// its own memory model and a timeline-based reference model checked every cycle.
module tb_sm_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;

    // Inputs as seen by the DUT at the most recent rising edge.
    logic          s_rst_n = 1'b0;
    logic          s_i_req = 1'b0;
    logic          s_d_req = 1'b0;
    logic          s_d_we  = 1'b0;
    logic [AW-1:0] s_i_addr = '0;
    logic [AW-1:0] s_d_addr = '0;
    logic [DW-1:0] s_d_wdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_rst_n   <= rst_n;
        s_i_req   <= i_req;
        s_d_req   <= d_req;
        s_d_we    <= d_we;
        s_i_addr  <= i_addr;
        s_d_addr  <= d_addr;
        s_d_wdata <= d_wdata;
    end

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hA5A5};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned Lat = (g == 0) ? 1 : 3;

        logic [DW-1:0] i_rdata;
        logic [DW-1:0] d_rdata;
        logic [DW-1:0] m_wdata;
        logic [DW-1:0] m_rdata;
        logic [AW-1:0] m_addr;
        logic          i_ack;
        logic          d_ack;
        logic          m_en;
        logic          m_we;
        logic          busy;
        logic [DW-1:0] mem  [logic [AW-1:0]];
        logic [DW-1:0] emem [logic [AW-1:0]];

        sm_mem_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_LATENCY(Lat)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_req  (i_req),
            .i_addr (i_addr),
            .i_rdata(i_rdata),
            .i_ack  (i_ack),
            .d_req  (d_req),
            .d_we   (d_we),
            .d_addr (d_addr),
            .d_wdata(d_wdata),
            .d_rdata(d_rdata),
            .d_ack  (d_ack),
            .m_en   (m_en),
            .m_we   (m_we),
            .m_addr (m_addr),
            .m_wdata(m_wdata),
            .m_rdata(m_rdata),
            .busy   (busy)
        );

        // Memory: read data appears Lat cycles after the m_en cycle, junk otherwise.
        initial begin : mem_proc
            logic [AW:0] pipe[$];
            logic [AW:0] ent;
            m_rdata = 32'hBAD00000;
            for (int i = 0; i < Lat; i++) pipe.push_back('0);
            forever begin
                @(negedge clk);
                if (m_en && m_we) mem[m_addr] = m_wdata;
                pipe.push_back({m_en && !m_we, m_addr});
                ent = pipe.pop_front();
                if (ent[AW]) begin
                    m_rdata = mem.exists(ent[AW-1:0]) ? mem[ent[AW-1:0]] : mem_init(ent[AW-1:0]);
                end else begin
                    m_rdata = 32'hBAD00000 | $urandom_range(0, 255);
                end
            end
        end

        // Reference: an access granted at edge E occupies the next Lat+2 cycles;
        // phase 1 strobes the memory, phase Lat+2 acks the granted port.
        initial begin : model_proc
            bit            act = 1'b0;
            int            ph = 0;
            bit            port_d = 1'b0;
            bit            we = 1'b0;
            bit            last_d = 1'b1;
            logic [AW-1:0] addr = '0;
            logic [DW-1:0] wdata = '0;
            logic [DW-1:0] e_i_rd = '0;
            logic [DW-1:0] e_d_rd = '0;
            logic [DW-1:0] val;
            string         p;
            p = $sformatf("L%0d", Lat);
            forever begin
                @(negedge clk);
                if (!rst_n || !s_rst_n) begin
                    act    = 1'b0;
                    last_d = 1'b1;
                    e_i_rd = '0;
                    e_d_rd = '0;
                end else if (act) begin
                    ph++;
                    if (ph == Lat + 2 && !we) begin
                        val = emem.exists(addr) ? emem[addr] : mem_init(addr);
                        if (port_d) e_d_rd = val;
                        else e_i_rd = val;
                    end
                    if (ph > Lat + 2) act = 1'b0;
                end else if (s_i_req || s_d_req) begin
                    port_d = s_d_req && (!s_i_req || !last_d);
                    last_d = port_d;
                    act    = 1'b1;
                    ph     = 1;
                    we     = port_d && s_d_we;
                    addr   = port_d ? s_d_addr : s_i_addr;
                    wdata  = s_d_wdata;
                    if (we) emem[addr] = wdata;
                end

                chk({p, " busy"}, busy, act);
                chk({p, " m_en"}, m_en, act && ph == 1);
                chk({p, " i_ack"}, i_ack, act && ph == Lat + 2 && !port_d);
                chk({p, " d_ack"}, d_ack, act && ph == Lat + 2 && port_d);
                chk({p, " i_rdata"}, i_rdata, e_i_rd);
                chk({p, " d_rdata"}, d_rdata, e_d_rd);
                if (act && ph == 1) begin
                    chk({p, " m_addr"}, m_addr, addr);
                    chk({p, " m_we"}, m_we, we);
                    if (we) chk({p, " m_wdata"}, m_wdata, wdata);
                end
                if (!rst_n) begin
                    chk({p, " m_addr rst"}, m_addr, 0);
                    chk({p, " m_we rst"}, m_we, 0);
                    chk({p, " m_wdata rst"}, m_wdata, 0);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int en_cyc[$];
        logic [AW-1:0] en_addr[$];
        int nd0, nd1, ni1;
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        tick(3);
        chk("reset busy", g_lane[0].busy, 0);
        chk("reset i_rdata", g_lane[1].i_rdata, 0);
        rst_n = 1'b1;
        tick(2);

        // Single fetch, latency 1.
        i_req = 1'b1; i_addr = 32'h10;
        negs(2);
        chk("s1 m_en", g_lane[0].m_en, 1);
        chk("s1 m_addr", g_lane[0].m_addr, 32'h10);
        chk("s1 m_we", g_lane[0].m_we, 0);
        negs(1);
        chk("s1 wait i_ack", g_lane[0].i_ack, 0);
        negs(1);
        chk("s1 i_ack", g_lane[0].i_ack, 1);
        chk("s1 i_rdata", g_lane[0].i_rdata, 32'hDEADBEEF);
        tick();
        i_req = 1'b0;
        negs(1);
        chk("s1 i_ack once", g_lane[0].i_ack, 0);
        chk("s1 idle busy", g_lane[0].busy, 0);
        tick(10);

        // Simultaneous I and D after reset: I first, D four cycles later.
        do_reset();
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        negs(2);
        chk("s2 first addr", g_lane[0].m_addr, 32'h10);
        negs(2);
        chk("s2 i_ack", g_lane[0].i_ack, 1);
        negs(2);
        chk("s2 d m_en", g_lane[0].m_en, 1);
        chk("s2 d m_addr", g_lane[0].m_addr, 32'h20);
        negs(2);
        chk("s2 d_ack", g_lane[0].d_ack, 1);
        chk("s2 no i_ack", g_lane[0].i_ack, 0);
        chk("s2 d_rdata", g_lane[0].d_rdata, 32'h0020A5A5);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        tick(16);

        // D write, then read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        negs(2);
        chk("s3 m_we", g_lane[0].m_we, 1);
        chk("s3 m_addr", g_lane[0].m_addr, 32'h40);
        chk("s3 m_wdata", g_lane[0].m_wdata, 32'h12345678);
        negs(2);
        chk("s3 d_ack", g_lane[0].d_ack, 1);
        chk("s3 d_rdata kept", g_lane[0].d_rdata, 32'h0020A5A5);
        tick();
        d_we = 1'b0;
        negs(2);
        chk("s3 rd m_we", g_lane[0].m_we, 0);
        negs(2);
        chk("s3 rd d_rdata", g_lane[0].d_rdata, 32'h12345678);
        tick();
        d_req = 1'b0;
        tick(16);

        // Continuous contention, latency 3: strict alternation every 6 cycles.
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (g_lane[1].m_en) begin
                en_cyc.push_back(c);
                en_addr.push_back(g_lane[1].m_addr);
            end
        end
        chk("s4 grant count", en_cyc.size(), 7);
        for (int k = 0; k < en_cyc.size(); k++) begin
            chk($sformatf("s4 grant %0d addr", k), en_addr[k], (k % 2) ? 32'h200 : 32'h100);
            if (k > 0) chk($sformatf("s4 spacing %0d", k), en_cyc[k] - en_cyc[k-1], 6);
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        tick(16);

        // Reset during WAIT (latency 3) abandons the access; I restarts first.
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h200;
        negs(3);
        chk("s5 busy in wait", g_lane[1].busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("s5 async busy", g_lane[1].busy, 0);
        chk("s5 async m_en", g_lane[1].m_en, 0);
        chk("s5 async m_addr", g_lane[1].m_addr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        negs(2);
        chk("s5 restart m_en", g_lane[1].m_en, 1);
        chk("s5 restart addr", g_lane[1].m_addr, 32'h300);
        negs(4);
        chk("s5 i_ack", g_lane[1].i_ack, 1);
        chk("s5 i_rdata", g_lane[1].i_rdata, 32'h0300A5A5);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        tick(16);

        // One-cycle D pulse while I is mid-access: never serviced.
        i_req = 1'b1; i_addr = 32'h500;
        tick(2);
        d_req = 1'b1; d_addr = 32'h600;
        tick();
        d_req = 1'b0; i_req = 1'b0;
        nd0 = 0; nd1 = 0; ni1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (g_lane[0].d_ack) nd0++;
            if (g_lane[1].d_ack) nd1++;
            if (g_lane[1].i_ack) ni1++;
        end
        chk("s6 L1 no d_ack", nd0, 0);
        chk("s6 L3 no d_ack", nd1, 0);
        chk("s6 L3 one i_ack", ni1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
